// File: rtl/vga_reg_refresh_seq_if.sv
// Register-file read handshake plus display-bank write bus between the refresh
// sequencer (master) and the arbiter/overlay side (slave).
interface vga_reg_refresh_seq_if;
  logic       mem_req;
  logic       mem_grant;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] mem_addr_out;
  logic [7:0] mem_data_out;
  logic       write_out;

  modport master (
    output mem_req, rd_addr, mem_addr_out, mem_data_out, write_out,
    input  mem_grant, rd_data, rd_valid
  );

  modport slave (
    input  mem_req, rd_addr, mem_addr_out, mem_data_out, write_out,
    output mem_grant, rd_data, rd_valid
  );
endinterface

// File: rtl/vga_reg_refresh_seq.sv
// Copies the clock/date/timer register window into the VGA overlay bank once
// per frame, during vertical blanking, one byte write per fetched address.
module vga_reg_refresh_seq #(
  parameter logic [7:0] FIRST_ADDR = 8'd40,
  parameter logic [7:0] LAST_ADDR  = 8'd51,
  parameter logic [3:0] TIMEOUT    = 4'd15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vsync,
  input  logic                          clear_err,
  vga_reg_refresh_seq_if.master         bus,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun,
  output logic                          timeout_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;

  state_t     state_q, state_d;
  logic       vsync_q, vsync_d;
  logic       armed_q, armed_d;
  logic [7:0] addr_q, addr_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic       mem_req_q, mem_req_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_data_q, mem_data_d;
  logic       write_q, write_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       overrun_q, overrun_d;
  logic       timeout_q, timeout_d;
  logic       advance, abort, set_to;

  always_comb begin
    state_d      = state_q;
    vsync_d      = vsync;
    // A falling edge only counts once VSync has been seen high since reset.
    armed_d      = armed_q | vsync;
    addr_d       = addr_q;
    tcnt_d       = tcnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    write_d      = 1'b0;
    frame_done_d = 1'b0;
    advance      = 1'b0;
    abort        = 1'b0;
    set_to       = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed_q && vsync_q && !vsync) begin
          state_d   = REQ;
          addr_d    = FIRST_ADDR;
          mem_req_d = 1'b1;
        end
      end
      REQ: begin
        if (vsync) begin
          abort = 1'b1;
        end else if (bus.mem_grant) begin
          state_d   = WAIT;
          tcnt_d    = 4'd0;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (vsync) begin
          abort = 1'b1;
        end else if (bus.rd_valid) begin
          mem_addr_d = addr_q;
          mem_data_d = bus.rd_data;
          write_d    = 1'b1;
          state_d    = WRITE;
        end else if (tcnt_q >= TIMEOUT - 4'd1) begin
          tcnt_d  = TIMEOUT;
          set_to  = 1'b1;
          advance = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      WRITE: begin
        if (vsync) abort = 1'b1;
        else       advance = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (addr_q == LAST_ADDR) begin
        state_d      = DONE;
        frame_done_d = 1'b1;
      end else begin
        addr_d    = addr_q + 8'd1;
        state_d   = REQ;
        mem_req_d = 1'b1;
      end
    end

    if (abort) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
    end

    busy_d    = (state_d != IDLE);
    overrun_d = abort  | (overrun_q & ~clear_err);
    timeout_d = set_to | (timeout_q & ~clear_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b1;
      armed_q      <= 1'b0;
      addr_q       <= FIRST_ADDR;
      tcnt_q       <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 8'd0;
      mem_data_q   <= 8'd0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      armed_q      <= armed_d;
      addr_q       <= addr_d;
      tcnt_q       <= tcnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      write_q      <= write_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.rd_addr      = addr_q;
  assign bus.mem_addr_out = mem_addr_q;
  assign bus.mem_data_out = mem_data_q;
  assign bus.write_out    = write_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign overrun          = overrun_q;
  assign timeout_err      = timeout_q;

endmodule

// File: tb/tb_vga_reg_refresh_seq.sv
// Directed bench for the VGA register refresh sequencer: a behavioural register
// file answers each grant with RdData = addr + 8'h10 one cycle later.
module tb_vga_reg_refresh_seq;
  logic clk = 1'b0;
  logic rst, vsync, clear_err;
  logic busy, frame_done, overrun, timeout_err;

  vga_reg_refresh_seq_if bus();

  vga_reg_refresh_seq dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .clear_err   (clear_err),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc, nw, done_cyc, hold_left, clear_at;
  logic [7:0] hold_addr, to_addr, abort_addr;
  logic [7:0] wr_addr [0:63];
  logic [7:0] wr_data [0:63];
  logic       req_h   [0:255];
  logic [7:0] addr_h  [0:255];
  logic       te_h    [0:255];
  logic       ov_h    [0:255];
  logic       busy_h  [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; records outputs, then sets register-file inputs for the next edge.
  task automatic tick();
    logic       p_req, p_grant;
    logic [7:0] p_addr;
    p_req   = bus.mem_req;
    p_grant = bus.mem_grant;
    p_addr  = bus.rd_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 256) begin
      req_h[cyc]  = bus.mem_req;
      addr_h[cyc] = bus.rd_addr;
      te_h[cyc]   = timeout_err;
      ov_h[cyc]   = overrun;
      busy_h[cyc] = busy;
    end
    if (bus.write_out) begin
      $display("cycle %0d: write addr=%0d data=%02h", cyc, bus.mem_addr_out, bus.mem_data_out);
      if (nw < 64) begin
        wr_addr[nw] = bus.mem_addr_out;
        wr_data[nw] = bus.mem_data_out;
      end
      nw++;
      if (bus.mem_addr_out == abort_addr) vsync = 1'b1;
    end
    if (frame_done && done_cyc == 0) done_cyc = cyc;
    bus.rd_valid = 1'b0;
    if (p_req && p_grant && p_addr != to_addr) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = p_addr + 8'h10;
    end
    if (bus.mem_req && bus.rd_addr == hold_addr && hold_left > 0) begin
      bus.mem_grant = 1'b0;
      hold_left--;
    end else begin
      bus.mem_grant = 1'b1;
    end
    clear_err = (clear_at != 0) && (cyc == clear_at - 1);
  endtask

  task automatic start_frame();
    cyc = 0; nw = 0; done_cyc = 0;
    vsync = 1'b0;
  endtask

  task automatic run_frame(input int exp_done, input int exp_writes, input int skip);
    int j;
    start_frame();
    while (done_cyc == 0 && cyc < 200) tick();
    check("done_cycle", done_cyc, exp_done);
    check("write_count", nw, exp_writes);
    j = 0;
    for (int a = 40; a <= 51; a++) begin
      if (a != skip) begin
        if (j < 64) begin
          check($sformatf("wr_addr[%0d]", j), wr_addr[j], a);
          check($sformatf("wr_data[%0d]", j), wr_data[j], a + 16);
        end
        j++;
      end
    end
    tick();
    check("frame_done_pulse", frame_done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    vsync = 1'b1;
    tick();
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_mem_req"},    bus.mem_req, 1'b0);
    check({pfx, "_rd_addr"},    bus.rd_addr, 8'd40);
    check({pfx, "_mem_addr"},   bus.mem_addr_out, 8'd0);
    check({pfx, "_mem_data"},   bus.mem_data_out, 8'd0);
    check({pfx, "_write"},      bus.write_out, 1'b0);
    check({pfx, "_busy"},       busy, 1'b0);
    check({pfx, "_frame_done"}, frame_done, 1'b0);
    check({pfx, "_overrun"},    overrun, 1'b0);
    check({pfx, "_timeout"},    timeout_err, 1'b0);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b1; clear_err = 1'b0;
    bus.mem_grant = 1'b1; bus.rd_valid = 1'b0; bus.rd_data = 8'h00;
    hold_addr = 8'hFF; hold_left = 0; to_addr = 8'hFF; abort_addr = 8'hFF; clear_at = 0;
    cyc = 0; nw = 0; done_cyc = 0;
    @(posedge clk); @(posedge clk); #1;
    check_reset("reset");
    rst = 1'b0;
    tick(); tick();

    // Normal frame: request one cycle after the falling edge, done at cycle 37.
    check("idle_mem_req", bus.mem_req, 1'b0);
    run_frame(37, 12, -1);
    check("first_req", req_h[1], 1'b1);
    check("first_rd_addr", addr_h[1], 8'd40);
    check("first_busy", busy_h[1], 1'b1);
    check("normal_overrun", overrun, 1'b0);
    check("normal_timeout", timeout_err, 1'b0);

    // Stray RdValid while idle must not produce a write.
    bus.rd_valid = 1'b1; bus.rd_data = 8'hEE;
    tick();
    check("stray_write", bus.write_out, 1'b0);
    check("stray_busy", busy, 1'b0);
    check("stray_hold_data", bus.mem_data_out, 8'h43);

    // Grant withheld 5 cycles for address 44.
    hold_addr = 8'd44; hold_left = 5;
    run_frame(42, 12, -1);
    for (int i = 13; i <= 18; i++) begin
      check($sformatf("hold_req[%0d]", i), req_h[i], 1'b1);
      check($sformatf("hold_addr[%0d]", i), addr_h[i], 8'd44);
    end
    check("hold_release", req_h[19], 1'b0);
    check("hold_timeout", timeout_err, 1'b0);
    hold_addr = 8'hFF;

    // Address 46 never answered: 15 WAIT cycles then skip to 47.
    to_addr = 8'd46;
    run_frame(50, 11, 46);
    check("to_not_early", te_h[34], 1'b0);
    check("to_set", te_h[35], 1'b1);
    check("to_next_req", req_h[35], 1'b1);
    check("to_next_addr", addr_h[35], 8'd47);
    check("to_overrun", overrun, 1'b0);
    to_addr = 8'hFF;

    // VSync rises right after the write to 44.
    abort_addr = 8'd44;
    start_frame();
    repeat (40) tick();
    check("ovr_writes", nw, 5);
    check("ovr_last_addr", wr_addr[4], 8'd44);
    check("ovr_before", ov_h[15], 1'b0);
    check("ovr_req_drop", req_h[16], 1'b0);
    check("ovr_set", ov_h[16], 1'b1);
    check("ovr_busy", busy_h[16], 1'b0);
    abort_addr = 8'hFF;
    run_frame(37, 12, -1);
    check("ovr_sticky", overrun, 1'b1);

    // ClearErr with both flags set.
    check("pre_clear_to", timeout_err, 1'b1);
    clear_err = 1'b1;
    tick();
    check("clear_overrun", overrun, 1'b0);
    check("clear_timeout", timeout_err, 1'b0);

    // ClearErr on the same edge as a new timeout: set wins.
    to_addr = 8'd46; clear_at = 35;
    run_frame(50, 11, 46);
    check("coinc_to_set", te_h[35], 1'b1);
    check("coinc_to_final", timeout_err, 1'b1);
    to_addr = 8'hFF; clear_at = 0;

    // Asynchronous reset while waiting for RdValid of address 41.
    start_frame();
    repeat (5) tick();
    check("pre_rst_addr", bus.mem_addr_out, 8'd40);
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    tick();
    #2 rst = 1'b0;
    cyc = 0;
    repeat (5) tick();
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("post_rst_req[%0d]", i), req_h[i], 1'b0);
      check($sformatf("post_rst_busy[%0d]", i), busy_h[i], 1'b0);
    end
    vsync = 1'b1;
    tick();
    run_frame(37, 12, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
